serial_comparator_ctrl: RTL and testbench

SERIAL_COMPARATOR_CTRL -- requirements
Module: serial_comparator_ctrl

---
 rtl/serial_comparator_ctrl.sv | 101 ++++++++++
 tb/tb_serial_comparator_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_comparator_ctrl.sv
// Bit-serial equality compare of two WIDTH-bit operands through a shared external
// 1-bit comparator. Optional early exit on first mismatch: SERIAL_CMP_EARLY_EXIT_EN.
module serial_comparator_ctrl #(
  parameter int WIDTH = 8,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_o,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [IW-1:0]    mism_idx
);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    cnt;
  logic [IW-1:0]    first_idx;
  logic             acc;
  logic             last_bit;
  logic             exit_run;
  logic             all_eq;

  assign last_bit = (cnt == IW'(WIDTH - 1));
  assign exit_run = last_bit || (EarlyExit && !cmp_o);
  assign all_eq   = acc & cmp_o;

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    cmp_a   = 1'b0;
    cmp_b   = 1'b0;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        busy  = 1'b1;
        cmp_a = a_q[cnt];
        cmp_b = b_q[cnt];
        if (exit_run) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      first_idx <= '0;
      acc       <= 1'b0;
      eq        <= 1'b0;
      mism_idx  <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        a_q       <= a;
        b_q       <= b;
        cnt       <= '0;
        first_idx <= '0;
        acc       <= 1'b1;
      end
    end else if (state == RUN) begin
      acc <= all_eq;
      // acc still high means this is the first mismatching bit
      if (acc && !cmp_o) first_idx <= cnt;
      if (!last_bit) cnt <= cnt + IW'(1);
      if (exit_run) begin
        eq <= all_eq;
        // a mismatch on the final evaluated bit is not yet in first_idx
        if (all_eq)   mism_idx <= '0;
        else if (acc) mism_idx <= cnt;
        else          mism_idx <= first_idx;
      end
    end
  end

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Directed bench for serial_comparator_ctrl (WIDTH=8) with a transaction-level
// model, per-cycle compare, result scoreboard and literal expectations.
module tb_serial_comparator_ctrl;
  localparam int W  = 8;
  localparam int IW = 3;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam int LAT_10 = 6;
  localparam int LAT_06 = 4;
  localparam int LAT_FF = 2;
  localparam int LAT_21 = 2;
`else
  localparam int LAT_10 = 9;
  localparam int LAT_06 = 9;
  localparam int LAT_FF = 9;
  localparam int LAT_21 = 9;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cmp_a, cmp_b, cmp_o;
  logic          busy, done, eq;
  logic [IW-1:0] mism_idx;

  int checks = 0;
  int errors = 0;

  // clock/reset
  always #5 clk = ~clk;

  serial_comparator_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_o(cmp_o),
    .busy(busy), .done(done), .eq(eq), .mism_idx(mism_idx)
  );

  assign cmp_o = ~(cmp_a ^ cmp_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction model: m_k = edges since acceptance (-1 when idle)
  int                m_k = -1;
  int                m_len = 0;
  logic [W-1:0]      m_a = '0, m_b = '0;
  logic              m_eq = 1'b0;
  logic [IW-1:0]     m_idx = '0;
  logic              r_eq = 1'b0;
  logic [IW-1:0]     r_idx = '0;
  logic [IW:0]       exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k = -1; m_eq = 1'b0; m_idx = '0; m_a = '0; m_b = '0;
      exp_q.delete();
    end else if (m_k < 0) begin
      if (start) begin
        m_a = a; m_b = b;
        r_eq = (a == b);
        r_idx = '0;
        for (int i = W - 1; i >= 0; i--) if (a[i] != b[i]) r_idx = IW'(i);
        m_len = W + 1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (!r_eq) m_len = int'(r_idx) + 2;
`endif
        exp_q.push_back({r_eq, r_idx});
        m_k = 0;
      end
    end else if (m_k < m_len - 1) begin
      m_k++;
      if (m_k == m_len - 1) begin
        m_eq = r_eq; m_idx = r_idx;
      end
    end else begin
      m_k = -1;
    end
  end

  // per-cycle compare against the model, plus result scoreboard on done
  always @(negedge clk) begin
    logic e_busy, e_done, e_a, e_b;
    e_busy = 1'b0; e_done = 1'b0; e_a = 1'b0; e_b = 1'b0;
    if (m_k >= 0 && m_k < m_len - 1) begin
      e_busy = 1'b1; e_a = m_a[m_k]; e_b = m_b[m_k];
    end else if (m_k >= 0) begin
      e_done = 1'b1;
    end
    chk("cyc_busy", busy, e_busy);
    chk("cyc_done", done, e_done);
    chk("cyc_cmp_a", cmp_a, e_a);
    chk("cyc_cmp_b", cmp_b, e_b);
    chk("cyc_eq", eq, m_eq);
    chk("cyc_mism_idx", mism_idx, m_idx);
    if (done === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_done", 1, 0);
      else chk("sb_result", {eq, mism_idx}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tbv);
    @(negedge clk);
    a = ta; b = tbv; start = 1'b1;
  endtask

  task automatic finish_cmp(input string tag, input logic l_eq, input int l_idx,
                            input int l_lat, output logic [W-1:0] seq);
    int n;
    int nb;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_accept_busy"}, busy, 1);
    n = 0; nb = 0; seq = '0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1 && nb < W) begin
        seq[nb] = cmp_a;
        nb++;
      end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_eq"}, eq, l_eq);
    chk({tag, "_mism_idx"}, mism_idx, l_idx);
    chk({tag, "_latency"}, n + 1, l_lat);
    @(posedge clk); #1;
    chk({tag, "_done_single"}, done, 0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] seq;
    int gap;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outputs", {busy, done, eq, mism_idx, cmp_a, cmp_b}, 8'h00);

    launch(8'hA5, 8'hA5); finish_cmp("a5_a5", 1'b1, 0, 9, seq);
    chk("a5_cmp_a_seq", seq, 8'hA5);
    launch(8'h10, 8'h00); finish_cmp("10_00", 1'b0, 4, LAT_10, seq);
    launch(8'h80, 8'h00); finish_cmp("80_00", 1'b0, 7, 9, seq);
    launch(8'h06, 8'h02); finish_cmp("06_02", 1'b0, 2, LAT_06, seq);
    launch(8'hFF, 8'h00); finish_cmp("ff_00", 1'b0, 0, LAT_FF, seq);

    // start held high; operand A changes mid-run
    launch(8'h0F, 8'h0F);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 8'hFF;
    wait_done("held1");
    chk("held1_eq", eq, 1);
    chk("held1_mism_idx", mism_idx, 0);
    gap = 0;
    while (busy !== 1'b1 && gap < 20) begin
      gap++;
      @(posedge clk); #1;
    end
    // DONE plus the IDLE cycle in which the held start is accepted
    chk("held_busy_gap", gap, 2);
    start = 1'b0;
    wait_done("held2");
    chk("held2_eq", eq, 0);
    chk("held2_mism_idx", mism_idx, 4);
    @(posedge clk); #1;

    // reset while bit 3 is being evaluated
    launch(8'hFF, 8'hFF); finish_cmp("pre_rst", 1'b1, 0, 9, seq);
    launch(8'hFF, 8'hFF);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bit3_busy_cmp_a", {busy, cmp_a}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {busy, done, eq, mism_idx, cmp_a, cmp_b}, 8'h00);
    @(negedge clk);
    rst = 1'b0; a = 8'h21; b = 8'h20; start = 1'b1;
    finish_cmp("post_rst", 1'b0, 0, LAT_21, seq);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
